trap_ctrl: RTL
==============

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, range 1..16: number of external interrupt sources.
REQ-002 SHALL have parameter IRQ_CODE_BASE, default 16: mcause code of source 0; source i uses IRQ_CODE_BASE+i.
REQ-003 SHALL have parameter ECALL_CODE, default 11: mcause code for environment call.
REQ-004 SHALL derive SRC_W = max(1, clog2(NUM_SRC)).
REQ-005 SHALL have port clk, in, 1: single clock for all state.
REQ-006 SHALL have port Rst_n, in, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port irq, in, NUM_SRC: interrupt requests, synchronous to clk.
REQ-008 SHALL have port irq_mask, in, NUM_SRC: per-source enable, 1 = enabled.
REQ-009 SHALL have port mie_global, in, 1: global interrupt enable.
REQ-010 SHALL have port ecall, in, 1: decoded ecall, one-cycle pulse.
REQ-011 SHALL have port trap_ret, in, 1: decoded mret.
REQ-012 SHALL have port mem_hold, in, 1: pipeline stall.
REQ-013 SHALL have port trapping, out, 1: handler active.
REQ-014 SHALL have port trigger_trap, out, 1: trap-entry strobe to fetch.
REQ-015 SHALL have port trigger_trap_ret, out, 1: trap-return strobe to fetch.
REQ-016 SHALL have port mcause, out, 32: cause of the current or last trap.
REQ-017 SHALL have port pending, out, NUM_SRC: registered pending vector.
REQ-018 SHALL have port active_id, out, SRC_W: source index of the current interrupt.

Function
REQ-019 SHALL implement FSM IDLE -> ENTER -> ACTIVE -> EXIT -> IDLE.
REQ-020 SHALL define req = ecall | (mie_global & |(pending & irq_mask)).
REQ-021 In IDLE, SHALL move to ENTER on the edge where req=1; otherwise stay in IDLE.
REQ-022 SHALL drive trigger_trap=1 only in ENTER, and trapping=1 in ENTER and ACTIVE.
REQ-023 SHALL move ENTER -> ACTIVE on the next edge.
REQ-024 In ACTIVE, SHALL move to EXIT when trap_ret=1.
REQ-025 SHALL drive trigger_trap_ret=1 only in EXIT, with trapping=0 there; EXIT -> IDLE next edge.
REQ-026 SHALL ignore trap_ret in IDLE, ENTER and EXIT.
REQ-027 SHALL ignore ecall outside IDLE (no nesting).
REQ-028 SHALL prioritise ecall over all interrupts, then lowest enabled pending index.
REQ-029 On IDLE->ENTER, SHALL register mcause: ecall -> {1'b0, ECALL_CODE}; irq i -> {1'b1, IRQ_CODE_BASE+i}, with the code zero-extended to 31 bits.
REQ-030 On IDLE->ENTER for an irq, SHALL register active_id = i.
REQ-031 SHALL hold mcause and active_id until the next entry.
REQ-032 Latency: ecall at edge k SHALL give trigger_trap=1 after edge k; irq asserted before edge k SHALL reach pending at edge k and trigger_trap after edge k+1.
REQ-033 While mem_hold=1, the FSM, mcause and active_id SHALL freeze, and strobes SHALL stay at their current level; pending capture continues.
REQ-034 SHALL allow back-to-back traps only after one IDLE cycle; req is not sampled in EXIT.

Reset
REQ-035 Rst_n=0 SHALL immediately force IDLE and set trapping, trigger_trap, trigger_trap_ret, mcause, pending and active_id to 0, including mid-trap.
REQ-036 SHALL start evaluating req on the first edge after Rst_n is released.

Configuration
REQ-037 Macro TRAP_CTRL_EDGE_IRQ_EN, when defined, SHALL set pending[i] on a rising edge of irq[i] (previous-cycle register) and hold it until that source is taken at IDLE->ENTER.
REQ-038 When taken at entry, pending[i] SHALL clear; a new edge in the same cycle SHALL win and keep it set.
REQ-039 Masked or mie_global=0 edges SHALL stay pending.
REQ-040 Without TRAP_CTRL_EDGE_IRQ_EN, pending SHALL be irq registered each cycle (level-sensitive), with no latching.

Verification (NUM_SRC=4, IRQ_CODE_BASE=16, ECALL_CODE=11)
REQ-041 irq=4'b0110, irq_mask=4'hF, mie_global=1 -> trigger_trap one cycle, 2 cycles after irq; mcause=0x80000011; active_id=1; trapping=1.
REQ-042 ecall and irq[0] in the same cycle while IDLE -> mcause=0x0000000B; trigger_trap 1 cycle later.
REQ-043 Edge mode: mie_global=0, one-cycle irq[3] pulse -> no trap and pending=4'b1000; set mie_global=1 -> trap with mcause=0x80000013, then pending=0.
REQ-044 trap_ret in ACTIVE -> trigger_trap_ret=1 for one cycle with trapping=0; trap_ret in IDLE -> no output change.
REQ-045 mem_hold=1 for 3 cycles during ENTER -> trigger_trap high 4 cycles, then ACTIVE.
REQ-046 Rst_n low in ACTIVE between edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: ecall/interrupt arbitration, mcause capture, entry/return strobes.
// Define TRAP_CTRL_EDGE_IRQ_EN for sticky rising-edge interrupt capture; default is level-sensitive.
module trap_ctrl #(
  parameter  int NUM_SRC       = 4,
  parameter  int IRQ_CODE_BASE = 16,
  parameter  int ECALL_CODE    = 11,
  localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               Rst_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               mie_global,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic               mem_hold,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [31:0]        mcause,
  output logic [NUM_SRC-1:0] pending,
  output logic [SRC_W-1:0]   active_id
);

  typedef enum logic [1:0] {IDLE, ENTER, ACTIVE, EXIT} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] cand;
  logic [SRC_W-1:0]   sel_id;
  logic               req;
  logic               enter;

  // Lowest enabled pending index wins; ecall outranks every interrupt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cand   = pending & irq_mask & {NUM_SRC{mie_global}};
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = SRC_W'(i);
    end
    req   = ecall | (|cand);
    enter = (state_q == IDLE) && req && !mem_hold;
  end

  always_comb begin
    state_d = state_q;
    if (!mem_hold) begin
      unique case (state_q)
        IDLE:    if (req) state_d = ENTER;
        ENTER:   state_d = ACTIVE;
        ACTIVE:  if (trap_ret) state_d = EXIT;
        EXIT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes decode straight from state, so a frozen FSM holds them at their level.
  assign trigger_trap     = (state_q == ENTER);
  assign trigger_trap_ret = (state_q == EXIT);
  assign trapping         = (state_q == ENTER) || (state_q == ACTIVE);

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset
  // so that reset clears the controller even mid-trap without waiting for a clock.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      mcause    <= '0;
      active_id <= '0;
    end else begin
      state_q <= state_d;
      if (enter) begin
        if (ecall) begin
          mcause <= {1'b0, 31'(ECALL_CODE)};
        end else begin
          mcause    <= {1'b1, 31'(IRQ_CODE_BASE) + 31'(sel_id)};
          active_id <= sel_id;
        end
      end
    end
  end

`ifdef TRAP_CTRL_EDGE_IRQ_EN
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] take_clr;

  // Only the interrupt actually taken at entry is cleared; a fresh edge in that cycle re-sets it.
  always_comb begin
    take_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      take_clr[i] = enter && !ecall && (sel_id == SRC_W'(i));
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~take_clr) | (irq & ~irq_q);
    end
  end
`else
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) pending <= '0;
    else        pending <= irq;
  end
`endif

endmodule
